c64_bus_arbiter: RTL

Parametrised system-bus arbiter and read-data concentrator for the c64 core. It generalises the fixed CPU/VIC/DMA address, write and read-data muxing used at the top level to N masters and M slaves. It adds a BA early-warning handshake with a configurable lead time, fixed-priority preemption, a registered read mux and sticky chip-select conflict detection. It sits between the CPU, VIC-II, expansion-port DMA and the memory/IO slaves decoded by the PLA.

---
 rtl/c64_pkg.sv | 16 +
 rtl/c64_prio_enc.sv | 26 ++
 rtl/c64_bus_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/c64_pkg.sv
// Shared definitions for the c64 system-bus arbiter.
//   state_t   : arbiter FSM states (CPU owns, BA warning, other master owns)
//   cnt_width : bits needed to hold values 0..max_val (minimum 1)
package c64_pkg;

   typedef enum logic [1:0] {
      ST_CPU  = 2'd0,
      ST_WARN = 2'd1,
      ST_MST  = 2'd2
   } state_t;

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/c64_prio_enc.sv
// Highest-set-bit encoder over vec[N-1:1]; bit 0 is ignored.
//   vec   in  N   request vector
//   idx   out IW  index of highest set bit above 0 (0 when none)
//   valid out 1   at least one of vec[N-1:1] is set
module c64_prio_enc #(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Ascending scan so the last hit (highest index) wins.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int k = 1; k < N; k++) begin
         if (vec[k]) begin
            idx   = IW'(k);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/c64_bus_arbiter.sv
// System-bus arbiter and read-data concentrator.
//   clk, reset              clock, synchronous active-high reset
//   phase_en                bus phase strobe; grant changes only here
//   req                     master bus requests (bit 0 ignored)
//   m_addr/m_we/m_wdata     packed per-master bus signals
//   grant, ba, aec          one-hot owner, BA warning, master 0 owns bus
//   bus_addr/bus_we/bus_wdata  owner's signals (combinational mux)
//   s_cs, s_rdata           slave selects and packed slave read data
//   bus_rdata               registered OR of selected slaves' data
//   cs_conflict             sticky multiple-select flag
module c64_bus_arbiter
   import c64_pkg::*;
#(
   parameter int unsigned NM      = 3,
   parameter int unsigned NS      = 12,
   parameter int unsigned AW      = 16,
   parameter int unsigned DW      = 8,
   parameter int unsigned BA_LEAD = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            phase_en,
   input  logic [NM-1:0]   req,
   input  logic [NM*AW-1:0] m_addr,
   input  logic [NM-1:0]   m_we,
   input  logic [NM*DW-1:0] m_wdata,
   output logic [NM-1:0]   grant,
   output logic            ba,
   output logic            aec,
   output logic [AW-1:0]   bus_addr,
   output logic            bus_we,
   output logic [DW-1:0]   bus_wdata,
   input  logic [NS-1:0]   s_cs,
   input  logic [NS*DW-1:0] s_rdata,
   output logic [DW-1:0]   bus_rdata,
   output logic            cs_conflict
);

   localparam int unsigned IW = cnt_width(NM - 1);
   localparam int unsigned CW = cnt_width(BA_LEAD);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [NM-1:0] grant_q, grant_d;
   logic          ba_q, ba_d;
   logic [IW-1:0] hi_idx;
   logic          hi_valid;
   logic [DW-1:0] rd_or;
   logic          multi_cs;

   c64_prio_enc #(.N(NM), .IW(IW)) u_hi (
      .vec   (req),
      .idx   (hi_idx),
      .valid (hi_valid)
   );

   // Arbiter state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CPU;
         cnt_q   <= '0;
         owner_q <= '0;
         grant_q <= NM'(1);
         ba_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         ba_q    <= ba_d;
      end
   end

   // Next-state: BA lead countdown, then fixed-priority ownership at strobes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      ba_d    = ba_q;
      grant_d = '0;
      unique case (state_q)
         ST_CPU: begin
            // Request detection is not gated by phase_en.
            if (hi_valid) begin
               state_d = ST_WARN;
               cnt_d   = CW'(BA_LEAD);
               ba_d    = 1'b1;
            end
         end
         ST_WARN: begin
            // A request drop beats a coincident strobe.
            if (!hi_valid) begin
               state_d = ST_CPU;
               cnt_d   = '0;
               ba_d    = 1'b0;
            end else if (phase_en) begin
               if (cnt_q == '0) begin
                  state_d = ST_MST;
                  owner_d = hi_idx;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
         ST_MST: begin
            // Preemption and hand-down both resolve to the current highest request.
            if (phase_en) begin
               if (!hi_valid) begin
                  state_d = ST_CPU;
                  owner_d = '0;
                  ba_d    = 1'b0;
               end else begin
                  owner_d = hi_idx;
               end
            end
         end
         default: begin
            state_d = ST_CPU;
            cnt_d   = '0;
            owner_d = '0;
            ba_d    = 1'b0;
         end
      endcase
      for (int k = 0; k < NM; k++) begin
         if (owner_d == IW'(k)) grant_d[k] = 1'b1;
      end
   end

   assign grant = grant_q;
   assign ba    = ba_q;
   assign aec   = grant_q[0];

   // Owner's address/write mux; defaults to master 0.
   always_comb begin
      bus_addr  = m_addr[AW-1:0];
      bus_we    = m_we[0];
      bus_wdata = m_wdata[DW-1:0];
      for (int k = 1; k < NM; k++) begin
         if (owner_q == IW'(k)) begin
            bus_addr  = m_addr[k*AW +: AW];
            bus_we    = m_we[k];
            bus_wdata = m_wdata[k*DW +: DW];
         end
      end
   end

   // Read OR-reduce over selected slaves.
   always_comb begin
      rd_or = '0;
      for (int j = 0; j < NS; j++) begin
         if (s_cs[j]) rd_or = rd_or | s_rdata[j*DW +: DW];
      end
   end

   assign multi_cs = ($countones(s_cs) > 1);

   // Registered read data and sticky conflict flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus_rdata   <= '0;
         cs_conflict <= 1'b0;
      end else begin
         bus_rdata <= rd_or;
         if (multi_cs) cs_conflict <= 1'b1;
      end
   end

endmodule
